// File: rtl/gate3_sweep_checker.sv
// rtl/gate3_sweep_checker.sv - exhaustive 8-vector self-check sequencer for one 3-input gate
// Optional feature macro: GATE_SWEEP_STOP_ON_FAIL_EN (end the sweep at the first mismatching vector)
module gate3_sweep_checker #(
   parameter logic [7:0] EXPECT        = 8'h7F,
   parameter int         SETTLE_CYCLES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       gate_y,
   output logic       gate_a,
   output logic       gate_b,
   output logic       gate_c,
   output logic [2:0] vec_idx,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [3:0] err_count,
   output logic [7:0] fail_mask
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_DRIVE  = 2'd1;
   localparam logic [1:0] ST_SAMPLE = 2'd2;
   localparam logic [1:0] ST_DONE   = 2'd3;

   // Settle counter runs 0..SETTLE_CYCLES-1 while a vector is held.
   localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

   logic [1:0] state_q, state_d;
   logic [2:0] vec_idx_q, vec_idx_d;
   logic [3:0] settle_q, settle_d;
   logic [3:0] err_count_q, err_count_d;
   logic [7:0] fail_mask_q, fail_mask_d;
   logic       pass_q, pass_d;

   logic       mismatch;
   logic [7:0] vec_onehot;
   logic [3:0] err_next;
   logic [7:0] mask_next;
   logic       last_vec;
   logic       end_sweep;

   // Compare the sampled gate output against the truth table and precompute the updated tallies.
   always_comb begin
      mismatch   = (gate_y != EXPECT[vec_idx_q]);
      vec_onehot = 8'b1 << vec_idx_q;
      err_next   = mismatch ? (err_count_q + 4'd1) : err_count_q;
      mask_next  = mismatch ? (fail_mask_q | vec_onehot) : fail_mask_q;
      last_vec   = (vec_idx_q == 3'd7);
`ifdef GATE_SWEEP_STOP_ON_FAIL_EN
      end_sweep  = last_vec || mismatch;
`else
      end_sweep  = last_vec;
`endif
   end

   // Next-state logic: walk the eight vectors, holding each for the settle time then sampling once.
   always_comb begin
      state_d     = state_q;
      vec_idx_d   = vec_idx_q;
      settle_d    = settle_q;
      err_count_d = err_count_q;
      fail_mask_d = fail_mask_q;
      pass_d      = pass_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d     = ST_DRIVE;
               vec_idx_d   = 3'd0;
               settle_d    = 4'd0;
               err_count_d = 4'd0;
               fail_mask_d = 8'd0;
               pass_d      = 1'b0;
            end
         end
         ST_DRIVE: begin
            if (settle_q == SETTLE_LAST) begin
               state_d = ST_SAMPLE;
            end else begin
               settle_d = settle_q + 4'd1;
            end
         end
         ST_SAMPLE: begin
            err_count_d = err_next;
            fail_mask_d = mask_next;
            if (end_sweep) begin
               // Verdict is registered here so it is already valid during the DONE cycle.
               state_d = ST_DONE;
               pass_d  = (err_next == 4'd0);
            end else begin
               state_d   = ST_DRIVE;
               vec_idx_d = vec_idx_q + 3'd1;
               settle_d  = 4'd0;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State registers with synchronous reset that overrides everything, including mid-sweep.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         vec_idx_q   <= 3'd0;
         settle_q    <= 4'd0;
         err_count_q <= 4'd0;
         fail_mask_q <= 8'd0;
         pass_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         vec_idx_q   <= vec_idx_d;
         settle_q    <= settle_d;
         err_count_q <= err_count_d;
         fail_mask_q <= fail_mask_d;
         pass_q      <= pass_d;
      end
   end

   // Gate inputs follow the vector only while it is applied; they rest at zero otherwise.
   always_comb begin
      busy      = (state_q == ST_DRIVE) || (state_q == ST_SAMPLE);
      done      = (state_q == ST_DONE);
      gate_a    = busy & vec_idx_q[2];
      gate_b    = busy & vec_idx_q[1];
      gate_c    = busy & vec_idx_q[0];
      vec_idx   = vec_idx_q;
      pass      = pass_q;
      err_count = err_count_q;
      fail_mask = fail_mask_q;
   end

endmodule

// File: tb/tb_gate3_sweep_checker.sv
// tb/tb_gate3_sweep_checker.sv - table-driven self-checking bench for gate3_sweep_checker
module tb_gate3_sweep_checker;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       gate_y;
   logic       gate_a, gate_b, gate_c;
   logic [2:0] vec_idx;
   logic       busy, done, pass;
   logic [3:0] err_count;
   logic [7:0] fail_mask;

   // 0 = ideal NAND3, 1 = stuck at 1, 2 = stuck at 0
   logic [1:0] mode;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      string      name;
      logic [1:0] mode;
      logic       exp_pass;
      logic [3:0] exp_err;
      logic [7:0] exp_mask;
      int         exp_lat;
   } sweep_vec_t;

   sweep_vec_t table_v[5];

   always #5 clk = ~clk;

   assign gate_y = (mode == 2'd0) ? ~(gate_a & gate_b & gate_c) : (mode == 2'd1);

   gate3_sweep_checker #(.EXPECT(8'h7F), .SETTLE_CYCLES(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .gate_y    (gate_y),
      .gate_a    (gate_a),
      .gate_b    (gate_b),
      .gate_c    (gate_c),
      .vec_idx   (vec_idx),
      .busy      (busy),
      .done      (done),
      .pass      (pass),
      .err_count (err_count),
      .fail_mask (fail_mask)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, " vec_idx"},   32'(vec_idx), 32'd0);
      check({tag, " gate_abc"},  32'({gate_a, gate_b, gate_c}), 32'd0);
      check({tag, " busy"},      32'(busy), 32'd0);
      check({tag, " done"},      32'(done), 32'd0);
      check({tag, " pass"},      32'(pass), 32'd0);
      check({tag, " err_count"}, 32'(err_count), 32'd0);
      check({tag, " fail_mask"}, 32'(fail_mask), 32'd0);
   endtask

   // Pulses start, traces every busy cycle, then checks the verdict in the DONE cycle and in IDLE.
   task automatic run_sweep(input sweep_vec_t v);
      int cyc;
      int o;
      mode  = v.mode;
      start = 1'b1;
      step();
      start = 1'b0;
      // now in cycle k+1: counters must already be cleared
      check({v.name, " start busy"},  32'(busy), 32'd1);
      check({v.name, " start err"},   32'(err_count), 32'd0);
      check({v.name, " start mask"},  32'(fail_mask), 32'd0);
      check({v.name, " start pass"},  32'(pass), 32'd0);
      cyc = 1;
      while (!done && cyc < 100) begin
         if (cyc <= 24) begin
            o = cyc - 1;
            if ((vec_idx !== 3'(o / 3)) || ({gate_a, gate_b, gate_c} !== 3'(o / 3)) || (busy !== 1'b1)) begin
               check({v.name, " trace vec/abc/busy"}, {20'd0, vec_idx, 1'b0, gate_a, gate_b, gate_c, 3'd0, busy},
                     {20'd0, 3'(o / 3), 1'b0, 3'(o / 3), 3'd0, 1'b1});
            end else begin
               n_tests++;
            end
         end
         step();
         cyc++;
      end
      check({v.name, " done latency"}, 32'(cyc), 32'(v.exp_lat));
      check({v.name, " done busy"},    32'(busy), 32'd0);
      check({v.name, " done abc"},     32'({gate_a, gate_b, gate_c}), 32'd0);
      check({v.name, " pass"},         32'(pass), 32'(v.exp_pass));
      check({v.name, " err_count"},    32'(err_count), 32'(v.exp_err));
      check({v.name, " fail_mask"},    32'(fail_mask), 32'(v.exp_mask));
      step();
      check({v.name, " idle done"},    32'(done), 32'd0);
      check({v.name, " idle busy"},    32'(busy), 32'd0);
      check({v.name, " held pass"},    32'(pass), 32'(v.exp_pass));
      check({v.name, " held err"},     32'(err_count), 32'(v.exp_err));
      check({v.name, " held mask"},    32'(fail_mask), 32'(v.exp_mask));
   endtask

   initial begin
      int cnt;
      table_v[0] = '{"ideal",   2'd0, 1'b1, 4'd0, 8'h00, 25};
      table_v[1] = '{"stuck1",  2'd1, 1'b0, 4'd1, 8'h80, 25};
`ifdef GATE_SWEEP_STOP_ON_FAIL_EN
      table_v[2] = '{"stuck0",  2'd2, 1'b0, 4'd1, 8'h01, 4};
`else
      table_v[2] = '{"stuck0",  2'd2, 1'b0, 4'd7, 8'h7F, 25};
`endif
      table_v[3] = '{"ideal2",  2'd0, 1'b1, 4'd0, 8'h00, 25};
      table_v[4] = '{"stuck1b", 2'd1, 1'b0, 4'd1, 8'h80, 25};

      mode  = 2'd0;
      rst   = 1'b1;
      start = 1'b1;
      step();
      step();
      check_all_zero("reset");
      rst   = 1'b0;
      start = 1'b0;
      step();
      check_all_zero("post-reset idle");

      for (int i = 0; i < 5; i++) begin
         run_sweep(table_v[i]);
      end

      // start while busy is ignored; reset mid-sweep at vector 3 clears everything
      mode  = 2'd2;
      start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 4; i++) step();
      check("midsweep vec before restart", 32'(vec_idx), 32'd1);
      start = 1'b1;
      step();
      start = 1'b0;
      check("restart ignored vec", 32'(vec_idx), 32'd1);
      check("restart ignored busy", 32'(busy), 32'd1);
      cnt = 0;
      while (vec_idx != 3'd3 && cnt < 50) begin
         step();
         cnt++;
      end
      check("reached vec 3", 32'(vec_idx), 32'd3);
      rst = 1'b1;
      step();
      check_all_zero("midsweep reset");
      rst = 1'b0;
      for (int i = 0; i < 3; i++) step();
      check("no queued start busy", 32'(busy), 32'd0);
      check("no queued start done", 32'(done), 32'd0);
      run_sweep(table_v[0]);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
